// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_t      - responder FSM encoding (IDLE, WAIT, RESP)
//   WAIT_CW      - width of the wait-state counter
//   WEN_READ     - byte-enable pattern that denotes a read
//   merge_bytes  - applies a byte-lane write mask to a 32-bit word
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_CW = 4;

  localparam logic [3:0] WEN_READ = 4'b0000;

  // Lanes with lane_we[i]=1 take the new byte, the rest keep the old byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bytewe_ram.sv
// bytewe_ram: single-port DEPTH_WORDS x 32 synchronous RAM with byte-lane
// write enables. The read port returns the post-write word (write-first).
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable for this edge
//   we     in   [3:0] byte write enables (WEN_READ = pure read)
//   idx    in   [IDX_W-1:0] word index
//   wdata  in   [31:0] lane-aligned write data
//   rdata  out  [31:0] registered read data, updated only when en=1
module bytewe_ram import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage update and write-first read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we != WEN_READ) begin
        mem[idx] <= merge_bytes(mem[idx], wdata, we);
      end
      rdata <= merge_bytes(mem[idx], wdata, we);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data port. Captures a
// request, inserts WAIT_CYCLES wait states while stalling the core, then
// performs the RAM access and pulses rvalid (with addr_err when the address
// falls outside the backing store).
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   req_en     in   request valid
//   req_wen    in   [3:0] byte write enables, 4'b0000 = read
//   req_addr   in   [31:0] byte address (bits [1:0] ignored)
//   req_wdata  in   [31:0] lane-aligned write data
//   rdata      out  [31:0] read data, valid with rvalid, held otherwise
//   rvalid     out  one-cycle response pulse
//   stall      out  hold the core's M stage
//   addr_err   out  one-cycle out-of-range flag alongside rvalid
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        stall,
  output logic        addr_err
);

  localparam int unsigned        IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0]        SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic               HAS_WAIT = (WAIT_CYCLES != 32'd0);
  // Unused when WAIT_CYCLES=0 (the WAIT state is never entered then).
  localparam logic [WAIT_CW-1:0] CNT_LOAD = WAIT_CW'(WAIT_CYCLES - 32'd1);
  localparam logic [WAIT_CW-1:0] CNT_ZERO = {WAIT_CW{1'b0}};
  localparam logic [WAIT_CW-1:0] CNT_ONE  = {{(WAIT_CW-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [WAIT_CW-1:0] cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic               in_range_r;
  logic [3:0]         wen_r;
  logic [31:0]        wdata_r;
  logic               use_ram_r;
  logic               rvalid_r;
  logic               addr_err_r;

  logic [31:0]        off_s;
  logic               live_in_range_s;
  logic [IDX_W-1:0]   live_idx_s;
  logic               ram_en_s;
  logic [3:0]         ram_we_s;
  logic [IDX_W-1:0]   ram_idx_s;
  logic [31:0]        ram_wdata_s;
  logic [31:0]        ram_rdata_s;

  // Range check / index of the live address, and steering of the RAM port.
  // The RAM fires on the edge that enters RESP: from IDLE with the live
  // request in a zero-wait build, otherwise from the last WAIT cycle using the
  // captured request. Gating with rst keeps a reset edge from committing.
  always_comb begin
    off_s           = req_addr - BASE_ADDR;
    live_in_range_s = ({1'b0, off_s} < SPAN);
    live_idx_s      = off_s[IDX_W+1:2];
    ram_en_s        = 1'b0;
    ram_we_s        = wen_r;
    ram_idx_s       = idx_r;
    ram_wdata_s     = wdata_r;
    case (state_r)
      IDLE: begin
        ram_we_s    = req_wen;
        ram_idx_s   = live_idx_s;
        ram_wdata_s = req_wdata;
        if (!HAS_WAIT) begin
          ram_en_s = rst & req_en & live_in_range_s;
        end else begin
          ram_en_s = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          ram_en_s = rst & in_range_r;
        end else begin
          ram_en_s = 1'b0;
        end
      end
      default: ram_en_s = 1'b0;
    endcase
  end

  bytewe_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en_s),
    .we   (ram_we_s),
    .idx  (ram_idx_s),
    .wdata(ram_wdata_s),
    .rdata(ram_rdata_s)
  );

  // Responder FSM: capture, wait-state countdown, response pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      idx_r      <= {IDX_W{1'b0}};
      in_range_r <= 1'b0;
      wen_r      <= WEN_READ;
      wdata_r    <= 32'h0;
      use_ram_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      rvalid_r   <= 1'b0;
      addr_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_en) begin
            idx_r      <= live_idx_s;
            in_range_r <= live_in_range_s;
            wen_r      <= req_wen;
            wdata_r    <= req_wdata;
            if (HAS_WAIT) begin
              cnt_r   <= CNT_LOAD;
              state_r <= WAIT;
            end else begin
              state_r    <= RESP;
              rvalid_r   <= 1'b1;
              addr_err_r <= ~live_in_range_s;
              use_ram_r  <= live_in_range_s;
            end
          end
        end
        WAIT: begin
          if (cnt_r == CNT_ZERO) begin
            state_r    <= RESP;
            rvalid_r   <= 1'b1;
            addr_err_r <= ~in_range_r;
            use_ram_r  <= in_range_r;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // rdata comes straight from the RAM's output register; out-of-range and
  // reset select zero. Both sources only change on clock edges.
  assign rdata    = use_ram_r ? ram_rdata_s : 32'h0;
  assign rvalid   = rvalid_r;
  assign addr_err = addr_err_r;
  // Held in the capture cycle and throughout WAIT; forced low under reset.
  assign stall    = rst & ((req_en & (state_r == IDLE) & HAS_WAIT) | (state_r == WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench. Instance a uses
// WAIT_CYCLES=2, instance b is a zero-wait build; both 1024 words at base 0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [3:0]  wen_a, wen_b;
  logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, stall_a, stall_b, err_a, err_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .rst(rst), .req_en(en_a), .req_wen(wen_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .rdata(rdata_a), .rvalid(rvalid_a), .stall(stall_a),
    .addr_err(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_b (
    .clk(clk), .rst(rst), .req_en(en_b), .req_wen(wen_b), .req_addr(addr_b),
    .req_wdata(wdata_b), .rdata(rdata_b), .rvalid(rvalid_b), .stall(stall_b),
    .addr_err(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit zw, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (zw) begin
      en_b = en; wen_b = wen; addr_b = addr; wdata_b = wdata;
    end else begin
      en_a = en; wen_a = wen; addr_a = addr; wdata_a = wdata;
    end
  endtask

  // Issue one request (called at posedge+1 in IDLE), count stall cycles and
  // capture-to-rvalid latency, then release the request.
  task automatic access(input bit zw, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic err, output int lat, output int stalls);
    bit done;
    done   = 1'b0;
    lat    = 0;
    stalls = 0;
    drive(zw, 1'b1, wen, addr, wdata);
    while (!done && lat < 20) begin
      #1;
      if ((zw ? stall_b : stall_a) === 1'b1) stalls++;
      @(posedge clk); #1;
      lat++;
      if ((zw ? rvalid_b : rvalid_a) === 1'b1) done = 1'b1;
    end
    check_eq("resp_seen", {31'd0, done}, 32'd1);
    rd  = zw ? rdata_b : rdata_a;
    err = zw ? err_b : err_a;
    #1;
    check_eq("stall_in_resp", {31'd0, (zw ? stall_b : stall_a)}, 32'd0);
    drive(zw, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_eq("rvalid_one_cycle", {31'd0, (zw ? rvalid_b : rvalid_a)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, st;

    // Reset held 3 cycles with a live request.
    rst = 1'b0;
    drive(1'b0, 1'b1, 4'hF, 32'h10, 32'h1111_1111);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdata", rdata_a, 32'h0);
    check_eq("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
    check_eq("rst_stall", {31'd0, stall_a}, 32'd0);
    check_eq("rst_err", {31'd0, err_a}, 32'd0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_eq("rst_state_idle", {30'd0, u_dut_a.state_r}, 32'd0);
    check_eq("rst_release_stall", {31'd0, stall_a}, 32'd0);

    // Full-word write then read, 2 wait states.
    access(1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF, rd, err, lat, st);
    check_eq("wr10_lat", lat, 32'd3);
    check_eq("wr10_stalls", st, 32'd3);
    check_eq("wr10_err", {31'd0, err}, 32'd0);
    access(1'b0, 4'h0, 32'h10, 32'h0, rd, err, lat, st);
    check_eq("rd10_lat", lat, 32'd3);
    check_eq("rd10_stalls", st, 32'd3);
    check_eq("rd10_data", rd, 32'hDEAD_BEEF);

    // Byte lanes.
    access(1'b0, 4'hF, 32'h20, 32'h1122_3344, rd, err, lat, st);
    access(1'b0, 4'b0010, 32'h20, 32'h0000_AA00, rd, err, lat, st);
    access(1'b0, 4'h0, 32'h20, 32'h0, rd, err, lat, st);
    check_eq("lane1_data", rd, 32'h1122_AA44);
    access(1'b0, 4'b1100, 32'h20, 32'h5566_0000, rd, err, lat, st);
    access(1'b0, 4'h0, 32'h20, 32'h0, rd, err, lat, st);
    check_eq("lane32_data", rd, 32'h5566_AA44);

    // Out of range (0x1000 would alias word 0 if not checked).
    access(1'b0, 4'hF, 32'h0, 32'hCAFE_0001, rd, err, lat, st);
    access(1'b0, 4'hF, 32'h1000, 32'hFFFF_FFFF, rd, err, lat, st);
    check_eq("oor_wr_err", {31'd0, err}, 32'd1);
    check_eq("oor_wr_lat", lat, 32'd3);
    access(1'b0, 4'h0, 32'h0, 32'h0, rd, err, lat, st);
    check_eq("oor_word0_kept", rd, 32'hCAFE_0001);
    check_eq("inrange_err", {31'd0, err}, 32'd0);
    access(1'b0, 4'h0, 32'h1000, 32'h0, rd, err, lat, st);
    check_eq("oor_rd_data", rd, 32'h0);
    check_eq("oor_rd_err", {31'd0, err}, 32'd1);

    // Abort: req_en drops mid-WAIT, captured write still commits.
    drive(1'b0, 1'b1, 4'hF, 32'h30, 32'h1234_5678);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 32'h3FC, 32'h0);
    lat = 1;
    check_eq("abort_stall_wait", {31'd0, stall_a}, 32'd1);
    while (rvalid_a !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("abort_lat", lat, 32'd3);
    @(posedge clk); #1;
    access(1'b0, 4'h0, 32'h30, 32'h0, rd, err, lat, st);
    check_eq("abort_committed", rd, 32'h1234_5678);

    // Reset during the last WAIT cycle: write must not commit.
    access(1'b0, 4'hF, 32'h34, 32'h0BAD_F00D, rd, err, lat, st);
    drive(1'b0, 1'b1, 4'hF, 32'h34, 32'hAAAA_5555);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rstmid_stall_before", {31'd0, stall_a}, 32'd1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_eq("rstmid_state", {30'd0, u_dut_a.state_r}, 32'd0);
    check_eq("rstmid_stall", {31'd0, stall_a}, 32'd0);
    check_eq("rstmid_rvalid", {31'd0, rvalid_a}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 4'h0, 32'h34, 32'h0, rd, err, lat, st);
    check_eq("rstmid_not_committed", rd, 32'h0BAD_F00D);

    // Zero-wait build.
    access(1'b1, 4'hF, 32'h0, 32'h0101_0101, rd, err, lat, st);
    check_eq("zw_wr_lat", lat, 32'd1);
    check_eq("zw_wr_stalls", st, 32'd0);
    access(1'b1, 4'hF, 32'h4, 32'h0202_0202, rd, err, lat, st);
    drive(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
    #1;
    check_eq("zw_b2b_stall0", {31'd0, stall_b}, 32'd0);
    @(posedge clk); #1;
    check_eq("zw_b2b_rvalid0", {31'd0, rvalid_b}, 32'd1);
    check_eq("zw_b2b_data0", rdata_b, 32'h0101_0101);
    drive(1'b1, 1'b1, 4'h0, 32'h4, 32'h0);
    #1;
    check_eq("zw_b2b_stall_resp", {31'd0, stall_b}, 32'd0);
    @(posedge clk); #1;
    check_eq("zw_resp_not_accepted", {31'd0, rvalid_b}, 32'd0);
    check_eq("zw_rdata_hold", rdata_b, 32'h0101_0101);
    check_eq("zw_b2b_stall_idle", {31'd0, stall_b}, 32'd0);
    @(posedge clk); #1;
    check_eq("zw_b2b_rvalid1", {31'd0, rvalid_b}, 32'd1);
    check_eq("zw_b2b_data1", rdata_b, 32'h0202_0202);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_eq("zw_b2b_end", {31'd0, rvalid_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
